// File: rtl/fifo_sram_pkg.sv
// Shared types and defaults for the FIFO-to-SRAM transfer engine.
package fifo_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 10;

  // One extra bit so a full 2^AW-word region length is representable.
  function automatic int calc_lw(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_sram_writer_addr_gen.sv
// Address and remaining-word counters for fifo_sram_writer.
// The reload input restarts the region from the latched base/length (circular mode).
module fifo_sram_addr_gen
  import fifo_sram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int LW = calc_lw(DEF_AW)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_base,
  input  logic [LW-1:0] i_len,
  input  logic          i_step,
  input  logic          i_reload,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [AW-1:0] r_base;
  logic [LW-1:0] r_len;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_rem;

  // Counter update: load on start, reload at region end, step per acknowledged word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base <= {AW{1'b0}};
      r_len  <= {LW{1'b0}};
      r_addr <= {AW{1'b0}};
      r_rem  <= {LW{1'b0}};
    end else if (i_load) begin
      r_base <= i_base;
      r_len  <= i_len;
      r_addr <= i_base;
      r_rem  <= i_len;
    end else if (i_reload) begin
      r_addr <= r_base;
      r_rem  <= r_len;
    end else if (i_step) begin
      r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
      r_rem  <= r_rem - {{(LW-1){1'b0}}, 1'b1};
    end else begin
      r_addr <= r_addr;
      r_rem  <= r_rem;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == {{(LW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/fifo_sram_writer.sv
// Drains a FWFT FIFO into a contiguous SRAM region with a req/ack write per word.
// FIFO_SRAM_WRITER_CIRC_EN enables ring-buffer mode (reload at region end, wrap pulse).
module fifo_sram_writer
  import fifo_sram_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int LW = calc_lw(AW)
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cfg_start,
  input  logic [AW-1:0] cfg_base,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_abort,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data_in,
  output logic          fifo_pop,
  output logic          sram_req,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_data_out,
  input  logic          sram_ack,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  state_t        r_state;
  logic          r_pop;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_busy;
  logic          r_done;
  logic          r_abort;

  logic [AW-1:0] w_addr;
  logic          w_last;
  logic          w_load;
  logic          w_step;
  logic          w_reload;
  logic          w_ack;
  logic          w_abort_now;

  assign w_load      = (r_state == ST_IDLE) && cfg_start;
  assign w_ack       = (r_state == ST_WRITE) && sram_ack;
  assign w_abort_now = r_abort || cfg_abort;

`ifdef FIFO_SRAM_WRITER_CIRC_EN
  logic r_wrap;
  assign w_step   = w_ack && !w_last;
  assign w_reload = w_ack && w_last;
  assign wrap     = r_wrap;
`else
  assign w_step   = w_ack;
  assign w_reload = 1'b0;
  assign wrap     = 1'b0;
`endif

  fifo_sram_addr_gen #(
    .AW (AW),
    .LW (LW)
  ) u_addr_gen (
    .i_clk    (wb_clk),
    .i_rst    (wb_rst),
    .i_load   (w_load),
    .i_base   (cfg_base),
    .i_len    (cfg_len),
    .i_step   (w_step),
    .i_reload (w_reload),
    .o_addr   (w_addr),
    .o_last   (w_last)
  );

  // Transfer FSM with all handshake and status outputs registered.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= ST_IDLE;
      r_pop   <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= {AW{1'b0}};
      r_data  <= {DW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
`ifdef FIFO_SRAM_WRITER_CIRC_EN
      r_wrap  <= 1'b0;
`endif
    end else begin
      r_pop  <= 1'b0;
      r_done <= 1'b0;
`ifdef FIFO_SRAM_WRITER_CIRC_EN
      r_wrap <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_abort <= 1'b0;
          if (cfg_start) begin
            r_busy <= 1'b1;
            if (cfg_len == {LW{1'b0}}) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (cfg_abort) begin
`ifdef FIFO_SRAM_WRITER_CIRC_EN
            r_state <= ST_DONE;
            r_done  <= 1'b1;
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`endif
          end else if (!fifo_empty) begin
            r_data  <= fifo_data_in;
            r_addr  <= w_addr;
            r_pop   <= 1'b1;
            r_req   <= 1'b1;
            r_state <= ST_WRITE;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        // A request is never withdrawn; an abort seen here waits for the ack.
        ST_WRITE: begin
          if (sram_ack) begin
            r_req   <= 1'b0;
            r_abort <= 1'b0;
            if (w_abort_now) begin
`ifdef FIFO_SRAM_WRITER_CIRC_EN
              r_state <= ST_DONE;
              r_done  <= 1'b1;
`else
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
`endif
            end else if (w_last) begin
`ifdef FIFO_SRAM_WRITER_CIRC_EN
              r_wrap  <= 1'b1;
              r_state <= ST_FETCH;
`else
              r_state <= ST_DONE;
              r_done  <= 1'b1;
`endif
            end else begin
              r_state <= ST_FETCH;
            end
          end else begin
            r_abort <= w_abort_now;
            r_state <= ST_WRITE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_pop      = r_pop;
  assign sram_req      = r_req;
  assign sram_addr     = r_addr;
  assign sram_data_out = r_data;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_fifo_sram_writer.sv
// Self-checking bench for fifo_sram_writer: FIFO/SRAM behavioural models,
// a table of directed transfers, plus abort, reset and circular-mode sequences.
module tb_fifo_sram_writer;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic          cfg_start;
  logic [AW-1:0] cfg_base;
  logic [LW-1:0] cfg_len;
  logic          cfg_abort;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_pop;
  logic          sram_req;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_out;
  logic          sram_ack;
  logic          busy;
  logic          done;
  logic          wrap;

  fifo_sram_writer #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_abort(cfg_abort), .fifo_empty(fifo_empty),
    .fifo_data_in(fifo_data_in), .fifo_pop(fifo_pop), .sram_req(sram_req),
    .sram_addr(sram_addr), .sram_data_out(sram_data_out), .sram_ack(sram_ack),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            pre;   // words available before the FIFO runs dry
    int            dly;   // SRAM wait cycles before ack
    logic [DW-1:0] d0;
  } vec_t;

  vec_t vecs [5];

  int errors = 0;
  int checks = 0;
  int pop_cnt, done_cnt, wrap_cnt, wr_cnt, wait_cnt, ack_delay;
  logic [DW-1:0] fifo_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_data_q [$];
  int wrap_at [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk);
    #1;
  endtask

  task automatic clr();
    pop_cnt = 0; done_cnt = 0; wrap_cnt = 0; wr_cnt = 0;
    wrap_at.delete(); fifo_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    cfg_base = b; cfg_len = l; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // FIFO and SRAM models, evaluated on the falling edge away from DUT sampling.
  initial begin
    wait_cnt = 0;
    forever begin
      @(negedge wb_clk);
      if (fifo_pop) begin
        pop_cnt++;
        chk("pop_with_req", {63'd0, sram_req}, 64'd1);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        else chk("pop_on_empty", 64'd1, 64'd0);
      end
      if (done) done_cnt++;
      if (wrap) begin wrap_cnt++; wrap_at.push_back(wr_cnt); end
      if (sram_req) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_req", {63'd0, sram_req}, 64'd0);
          sram_ack = 1'b0;
        end else begin
          chk("req_addr", {54'd0, sram_addr}, {54'd0, exp_addr_q[0]});
          chk("req_data", {32'd0, sram_data_out}, {32'd0, exp_data_q[0]});
          if (wait_cnt >= ack_delay) begin
            sram_ack = 1'b1;
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
            wr_cnt++;
            wait_cnt = 0;
          end else begin
            sram_ack = 1'b0;
            wait_cnt++;
          end
        end
      end else begin
        sram_ack = 1'b0;
        wait_cnt = 0;
      end
      fifo_empty   = (fifo_q.size() == 0);
      fifo_data_in = (fifo_q.size() > 0) ? fifo_q[0] : {DW{1'b0}};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic run_vec(input vec_t v);
    int c;
    clr();
    ack_delay = v.dly;
    for (int i = 0; i < int'(v.len); i++) begin
      exp_addr_q.push_back(AW'(int'(v.base) + i));
      exp_data_q.push_back(v.d0 + DW'(i));
      if (i < v.pre) fifo_q.push_back(v.d0 + DW'(i));
    end
    tick();
    start(v.base, v.len);
    if (v.pre < int'(v.len)) begin
      c = 0;
      while (wr_cnt < v.pre && c < 200) begin tick(); c++; end
      chk("starve_reached", {63'd0, c < 200}, 64'd1);
      repeat (5) tick();
      chk("starve_no_pop", 64'(pop_cnt), 64'(v.pre));
      chk("starve_busy", {63'd0, busy}, 64'd1);
      chk("starve_no_req", {63'd0, sram_req}, 64'd0);
      for (int i = v.pre; i < int'(v.len); i++) fifo_q.push_back(v.d0 + DW'(i));
    end
    c = 0;
    while (done_cnt == 0 && c < 300) begin tick(); c++; end
    chk("done_seen", 64'(done_cnt), 64'd1);
    if (v.len == {LW{1'b0}}) chk("len0_done_latency", {63'd0, c <= 1}, 64'd1);
    chk("busy_with_done", {63'd0, busy}, 64'd1);
    tick();
    chk("busy_after_done", {62'd0, busy, done}, 64'd0);
    chk("pop_count", 64'(pop_cnt), 64'(v.len));
    chk("write_count", 64'(wr_cnt), 64'(v.len));
    chk("words_left", 64'(exp_addr_q.size() + fifo_q.size()), 64'd0);
    chk("req_idle", {63'd0, sram_req}, 64'd0);
    if (v.len != {LW{1'b0}})
      chk("addr_holds", {54'd0, sram_addr}, {54'd0, AW'(int'(v.base) + int'(v.len) - 1)});
  endtask

  initial begin
    int c;
    vecs[0] = '{base: 10'h010, len: 11'd4, pre: 4, dly: 0, d0: 32'h0000_00A0};
    vecs[1] = '{base: 10'h100, len: 11'd6, pre: 3, dly: 3, d0: 32'h0000_5500};
    vecs[2] = '{base: 10'h3FF, len: 11'd2, pre: 2, dly: 1, d0: 32'h0000_00C0};
    vecs[3] = '{base: 10'h000, len: 11'd0, pre: 0, dly: 0, d0: 32'h0000_0000};
    vecs[4] = '{base: 10'h200, len: 11'd1, pre: 1, dly: 2, d0: 32'hDEAD_0000};

    wb_rst = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_abort = 1'b0;
    fifo_empty = 1'b1; fifo_data_in = '0; sram_ack = 1'b0; ack_delay = 0;
    clr();
    repeat (3) tick();
    chk("reset_outputs", {20'd0, fifo_pop, sram_req, sram_addr, sram_data_out, busy, done, wrap}, 64'd0);
    wb_rst = 1'b0;
    tick();

`ifndef FIFO_SRAM_WRITER_CIRC_EN
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort during WRITE: current word completes, no done pulse.
    clr(); ack_delay = 4;
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(AW'(10'h050 + i)); exp_data_q.push_back(32'hB0 + DW'(i));
      fifo_q.push_back(32'hB0 + DW'(i));
    end
    tick();
    start(10'h050, 11'd4);
    c = 0;
    while (!sram_req && c < 20) begin tick(); c++; end
    chk("abort_req_seen", {63'd0, sram_req}, 64'd1);
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    repeat (12) tick();
    chk("abort_word_done", 64'(wr_cnt), 64'd1);
    chk("abort_pops", 64'(pop_cnt), 64'd1);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle", {62'd0, busy, sram_req}, 64'd0);
`else
    // Circular mode: region of 3 words, 7 words supplied, then abort.
    clr(); ack_delay = 0;
    for (int i = 0; i < 7; i++) begin
      exp_addr_q.push_back(AW'(10'h020 + (i % 3))); exp_data_q.push_back(32'h70 + DW'(i));
      fifo_q.push_back(32'h70 + DW'(i));
    end
    tick();
    start(10'h020, 11'd3);
    c = 0;
    while (wr_cnt < 7 && c < 300) begin tick(); c++; end
    chk("circ_writes", 64'(wr_cnt), 64'd7);
    repeat (3) tick();
    chk("circ_wrap_count", 64'(wrap_cnt), 64'd2);
    if (wrap_at.size() >= 2) begin
      chk("circ_wrap1_after", 64'(wrap_at[0]), 64'd3);
      chk("circ_wrap2_after", 64'(wrap_at[1]), 64'd6);
    end
    chk("circ_no_done", 64'(done_cnt), 64'd0);
    chk("circ_busy", {63'd0, busy}, 64'd1);
    chk("circ_pops", 64'(pop_cnt), 64'd7);
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    c = 0;
    while (done_cnt == 0 && c < 10) begin tick(); c++; end
    chk("circ_abort_done", 64'(done_cnt), 64'd1);
    tick();
    chk("circ_abort_idle", {63'd0, busy}, 64'd0);
`endif

    // Start while busy is ignored; reset in WRITE clears outputs at once.
    clr(); ack_delay = 10;
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(AW'(10'h060 + i)); exp_data_q.push_back(32'hE0 + DW'(i));
      fifo_q.push_back(32'hE0 + DW'(i));
    end
    tick();
    start(10'h060, 11'd3);
    c = 0;
    while (!sram_req && c < 20) begin tick(); c++; end
    chk("rst_req_seen", {63'd0, sram_req}, 64'd1);
    start(10'h3A0, 11'd1);
    tick();
    chk("start_ignored_addr", {54'd0, sram_addr}, 64'h060);
    chk("start_ignored_req", {63'd0, sram_req}, 64'd1);
    wb_rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {20'd0, fifo_pop, sram_req, sram_addr, sram_data_out, busy, done, wrap}, 64'd0);
    tick();
    wb_rst = 1'b0;
    fifo_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    repeat (4) tick();
    chk("rst_stays_idle", {62'd0, busy, sram_req}, 64'd0);
    chk("rst_no_done", 64'(done_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
